// File: rtl/fil_pkg.sv
// Shared constants and helpers for the equaliser filter delay line.
//   FIL_LARGO     : default sample MSB index (25-bit samples)
//   FIL_DEPTH_MAX : largest supported tap count
//   fil_tap_lo    : low bit index of tap k inside a flattened tap bus
package fil_pkg;

  localparam int FIL_LARGO     = 24;
  localparam int FIL_DEPTH_MAX = 64;

  // Tap k occupies [(k+1)*w-1 : k*w]; tap 0 (newest) sits at the LSBs.
  function automatic int fil_tap_lo(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/fil_tap_reg.sv
// One sample register of the delay line.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset, clears the register
//   clr    : synchronous flush to zero (wins over en)
//   en     : load d_i on this edge
//   d_i    : incoming sample (from data input or previous tap)
//   q_o    : registered sample
module fil_tap_reg #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] data_d, data_q;

  always_comb begin
    data_d = data_q;
    if (clr)     data_d = '0;
    else if (en) data_d = d_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) data_q <= '0;
    else      data_q <= data_d;
  end

  assign q_o = data_q;

endmodule

// File: rtl/fil_delay_line.sv
// Multi-tap sample delay line feeding the FIR/IIR MAC stages.
// Holds the last DEPTH samples, shifting only on the en strobe.
//   clk    : rising-edge clock
//   rst    : asynchronous active-low reset
//   clr    : synchronous flush of taps and fill count (wins over en)
//   en     : sample strobe, one shift per high cycle
//   data_i : new sample, two's complement, LARGO+1 bits
//   data_o : oldest tap (tap DEPTH-1)
//   taps_o : all taps flattened, tap 0 (newest) at the LSBs
//   fill_o : number of valid samples held, saturates at DEPTH
//   full_o : fill_o == DEPTH
module fil_delay_line
  import fil_pkg::*;
#(
  parameter  int LARGO = FIL_LARGO,
  parameter  int DEPTH = 4,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       en,
  input  logic [LARGO:0]             data_i,
  output logic [LARGO:0]             data_o,
  output logic [(LARGO+1)*DEPTH-1:0] taps_o,
  output logic [CW-1:0]              fill_o,
  output logic                       full_o
);

  localparam int            W       = LARGO + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [DEPTH-1:0][W-1:0] tap_q;

  // Tap chain: tap 0 loads the input, tap k loads tap k-1.
  for (genvar k = 0; k < DEPTH; k++) begin : g_tap
    if (k == 0) begin : g_head
      fil_tap_reg #(.W(W)) u_tap (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (en),
        .d_i (data_i),
        .q_o (tap_q[k])
      );
    end else begin : g_body
      fil_tap_reg #(.W(W)) u_tap (
        .clk (clk),
        .rst (rst),
        .clr (clr),
        .en  (en),
        .d_i (tap_q[k-1]),
        .q_o (tap_q[k])
      );
    end
    assign taps_o[fil_tap_lo(k, W) +: W] = tap_q[k];
  end

  assign data_o = tap_q[DEPTH-1];

  // Fill counter: counts enabled shifts since reset/flush, saturating
  // at DEPTH so downstream sees "primed" without wrap-around.
  logic [CW-1:0] fill_d, fill_q;

  always_comb begin
    fill_d = fill_q;
    if (clr)                          fill_d = '0;
    else if (en && fill_q != DEPTH_C) fill_d = fill_q + CW'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) fill_q <= '0;
    else      fill_q <= fill_d;
  end

  assign fill_o = fill_q;
  assign full_o = (fill_q == DEPTH_C);

endmodule

// File: tb/tb_fil_delay_line.sv
// Self-checking bench for fil_delay_line (DEPTH=4 main instance, DEPTH=1
// instance for the single-register case). Reference: a queue of held
// samples, newest first, capped at DEPTH entries.
module tb_fil_delay_line;

  localparam int LARGO = 24;
  localparam int W     = LARGO + 1;
  localparam int D     = 4;
  localparam int OBSW  = W + 3 + 1 + W * D;

  logic           clk = 1'b0;
  logic           rst;
  logic           clr, en;
  logic [W-1:0]   data_i;
  logic [W-1:0]   data_o;
  logic [W*D-1:0] taps_o;
  logic [2:0]     fill_o;
  logic           full_o;

  logic           clr1, en1;
  logic [W-1:0]   data1_i, data1_o;
  logic [W-1:0]   taps1_o;
  logic [0:0]     fill1_o;
  logic           full1_o;

  always #5 clk = ~clk;

  fil_delay_line #(.LARGO(LARGO), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .clr(clr), .en(en), .data_i(data_i),
    .data_o(data_o), .taps_o(taps_o), .fill_o(fill_o), .full_o(full_o)
  );

  fil_delay_line #(.LARGO(LARGO), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .clr(clr1), .en(en1), .data_i(data1_i),
    .data_o(data1_o), .taps_o(taps1_o), .fill_o(fill1_o), .full_o(full1_o)
  );

  int n_checks = 0;
  int n_fails  = 0;

  // Reference model: held samples, index 0 = newest.
  logic [W-1:0] hist[$];

  function automatic logic [OBSW-1:0] exp_vec();
    logic [W*D-1:0] t = '0;
    logic [W-1:0]   old = '0;
    for (int k = 0; k < hist.size(); k++) t[k*W +: W] = hist[k];
    if (hist.size() == D) old = hist[D-1];
    return {old, 3'(hist.size()), (hist.size() == D), t};
  endfunction

  function automatic logic [OBSW-1:0] obs_vec();
    return {data_o, fill_o, full_o, taps_o};
  endfunction

  // Drive at negedge, advance one edge, update model, return at negedge.
  task automatic cyc(input logic c, input logic e, input logic [W-1:0] d);
    clr = c; en = e; data_i = d;
    @(posedge clk);
    if (!rst) hist.delete();
    else if (c) hist.delete();
    else if (e) begin
      hist.push_front(d);
      if (hist.size() > D) void'(hist.pop_back());
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; en = 1'b1; data_i = 25'h0ABCDE;
    en1 = 1'b0; clr1 = 1'b0; data1_i = '0;
    hist.delete();
    repeat (3) @(negedge clk);
    n_checks++;
    if (obs_vec() !== '0) begin
      n_fails++;
      $display("FAIL reset_hold: got %h expected 0", obs_vec());
    end
    rst = 1'b1;
    cyc(1'b0, 1'b1, 25'h0ABCDE);
    n_checks++;
    if (taps_o[W-1:0] !== 25'h0ABCDE || fill_o !== 3'd1) begin
      n_fails++;
      $display("FAIL reset_release: tap0 %h fill %0d expected 0abcde fill 1", taps_o[W-1:0], fill_o);
    end
  endtask

  task automatic test_fill();
    cyc(1'b1, 1'b0, '0);
    for (int i = 1; i <= 5; i++) begin
      cyc(1'b0, 1'b1, W'(i));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fails++;
        $display("FAIL fill_step%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
      if (i == 4) begin
        n_checks++;
        if (taps_o !== {25'd1, 25'd2, 25'd3, 25'd4} || data_o !== 25'd1 || full_o !== 1'b1) begin
          n_fails++;
          $display("FAIL fill_full: taps %h data %h full %b", taps_o, data_o, full_o);
        end
      end
      if (i == 5) begin
        n_checks++;
        if (data_o !== 25'd2 || fill_o !== 3'd4) begin
          n_fails++;
          $display("FAIL fill_saturate: data %h fill %0d expected 2 and 4", data_o, fill_o);
        end
      end
    end
  endtask

  task automatic test_gaps();
    logic [W-1:0] s;
    cyc(1'b1, 1'b0, '0);
    for (int i = 1; i <= 4; i++) begin
      s = W'(i * 10);
      n_checks++;
      if (data_o !== 25'd0) begin
        n_fails++;
        $display("FAIL gap_early%0d: data %h expected 0", i, data_o);
      end
      cyc(1'b0, 1'b1, s);
      for (int g = 0; g < 2; g++) begin
        cyc(1'b0, 1'b0, W'($urandom));
        n_checks++;
        if (obs_vec() !== exp_vec()) begin
          n_fails++;
          $display("FAIL gap_hold%0d_%0d: got %h expected %h", i, g, obs_vec(), exp_vec());
        end
      end
    end
    n_checks++;
    if (data_o !== 25'd10) begin
      n_fails++;
      $display("FAIL gap_out: data %h expected 00000a", data_o);
    end
  endtask

  task automatic test_flush();
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, W'($urandom));
    cyc(1'b1, 1'b1, 25'd99);
    n_checks++;
    if (obs_vec() !== '0) begin
      n_fails++;
      $display("FAIL flush: got %h expected 0", obs_vec());
    end
    cyc(1'b0, 1'b1, 25'd7);
    n_checks++;
    if (obs_vec() !== exp_vec() || taps_o[W-1:0] !== 25'd7 || fill_o !== 3'd1) begin
      n_fails++;
      $display("FAIL flush_recover: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1, W'($urandom));
    en = 1'b1; data_i = W'($urandom);
    #2 rst = 1'b0;
    #1;
    hist.delete();
    n_checks++;
    if (obs_vec() !== '0) begin
      n_fails++;
      $display("FAIL async_reset: got %h expected 0", obs_vec());
    end
    @(negedge clk);
    cyc(1'b1, 1'b1, 25'h1234);
    cyc(1'b0, 1'b1, 25'h5678);
    n_checks++;
    if (obs_vec() !== '0) begin
      n_fails++;
      $display("FAIL reset_held: got %h expected 0", obs_vec());
    end
    rst = 1'b1;
    cyc(1'b0, 1'b1, 25'h00F00D);
    n_checks++;
    if (obs_vec() !== exp_vec()) begin
      n_fails++;
      $display("FAIL reset_rerelease: got %h expected %h", obs_vec(), exp_vec());
    end
  endtask

  task automatic test_depth1();
    logic [W-1:0] v [2];
    v[0] = 25'h1000000; v[1] = 25'h0FFFFFF;
    en = 1'b0; clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      en1 = 1'b1; data1_i = v[i];
      @(posedge clk);
      @(negedge clk);
      en1 = 1'b0; data1_i = ~v[i];
      n_checks++;
      if (data1_o !== v[i] || taps1_o !== v[i] || fill1_o !== 1'b1 || full1_o !== 1'b1) begin
        n_fails++;
        $display("FAIL depth1_%0d: data %h fill %0d full %b expected %h 1 1", i, data1_o, fill1_o, full1_o, v[i]);
      end
    end
    repeat (2) @(negedge clk);
    n_checks++;
    if (data1_o !== 25'h0FFFFFF || fill1_o !== 1'b1) begin
      n_fails++;
      $display("FAIL depth1_hold: data %h fill %0d", data1_o, fill1_o);
    end
    clr1 = 1'b1; en1 = 1'b1;
    @(negedge clk);
    clr1 = 1'b0; en1 = 1'b0;
    n_checks++;
    if (data1_o !== '0 || fill1_o !== 1'b0 || full1_o !== 1'b0) begin
      n_fails++;
      $display("FAIL depth1_clr: data %h fill %0d full %b", data1_o, fill1_o, full1_o);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 19) == 0), $urandom_range(0, 1) == 1, W'($urandom));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fails++;
        $display("FAIL random%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    cyc(1'b1, 1'b0, '0);
    for (int i = 0; i < 12; i++) begin
      cyc(1'b0, 1'b1, W'($urandom));
      n_checks++;
      if (obs_vec() !== exp_vec()) begin
        n_fails++;
        $display("FAIL b2b%0d: got %h expected %h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_gaps();
    test_flush();
    test_async_reset();
    test_depth1();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/fil_delay_line.md
Name: fil_delay_line

Overview:
Parametrised multi-tap sample delay line for the equaliser filter datapath. It is the successor to the single-stage filter register. It holds the last DEPTH input samples, shifts only on a sample strobe, and exposes every tap plus the oldest sample. It sits between the audio sample source and the FIR/IIR multiply-accumulate stages, which read all taps in parallel. A fill counter tells downstream logic when the history is fully primed.

Parameters:
LARGO, 24, MSB index of a sample; sample width is LARGO+1 bits (25 by default).
DEPTH, 4, number of delay taps; legal range 1..64.
CW, $clog2(DEPTH+1), fill-counter width; derived, never overridden.

Ports:
clk  input  1  system clock; all state changes on rising edge.
rst  input  1  reset, asynchronous, active-low; clears all state while low.
clr  input  1  synchronous flush; zeroes taps and fill counter.
en  input  1  sample strobe; one shift per cycle high.
data_i  input  LARGO+1  new sample, two's complement.
data_o  output  LARGO+1  oldest tap (tap DEPTH-1).
taps_o  output  (LARGO+1)*DEPTH  all taps flattened; tap k at bits [(k+1)*(LARGO+1)-1 : k*(LARGO+1)]; tap 0 is newest.
fill_o  output  CW  number of valid samples held, saturating at DEPTH.
full_o  output  1  high when fill_o == DEPTH.

Behaviour:
- Reset (rst low, asynchronous): all taps = 0, fill_o = 0, full_o = 0. Outputs read zero combinationally from registers while rst is low. Release is clean on the next edge.
- Clock edge, precedence from highest to lowest: clr, then en, then hold.
- clr = 1: all taps <= 0 and fill <= 0, regardless of en. The sample on data_i is discarded.
- en = 1, clr = 0: tap0 <= data_i, and tap k <= tap k-1 for k = 1..DEPTH-1. fill <= min(fill+1, DEPTH).
- en = 0, clr = 0: all state holds. No drift.
- Latency: a sample presented with en appears on taps_o tap 0 one clock later. It reaches data_o after DEPTH enabled edges. Gaps in en do not count.
- DEPTH = 1: data_o = tap0. The block behaves as an enabled version of the single filter register. fill goes 0→1 and then saturates.
- Fill saturation: once at DEPTH, further en leaves fill_o = DEPTH and full_o = 1. No wrap-around.
- Back-to-back en on every cycle is legal. Throughput is one sample per clock.
- No arithmetic is done on samples. Bits pass through unchanged with sign preserved.
- full_o and fill_o are registered-derived: full_o is a compare on the registered count with no extra latency.
- rst asserted mid-stream overrides everything immediately. clr has no effect while rst is low.
- Non-blocking assignments only. No latches.

Decomposition:
- Shared package (fil_pkg): default sample MSB constant FIL_LARGO = 24, FIL_DEPTH_MAX = 64, and the tap slice-index helper function.
- One natural sub-module, fil_tap_reg: a single LARGO+1 register with async active-low rst, sync clr, and en. It is instantiated DEPTH times in a generate loop, chained tap k-1 → tap k.
- Fill counter and full flag live in the top module.

Test Plan:
1. Reset: hold rst low, drive data_i = 25'h0ABCDE with en = 1 → taps_o = 0, data_o = 0, fill_o = 0, full_o = 0. Release rst; the first en edge gives tap0 = 25'h0ABCDE and fill_o = 1.
2. Fill and latency (DEPTH = 4): en every cycle with samples 1, 2, 3, 4, 5 → after the 4th edge taps = {4, 3, 2, 1}, data_o = 1, full_o = 1. After the 5th edge data_o = 2 and fill_o stays at 4.
3. Strobe gaps: samples 10, 20, 30, 40 with en high only on every third cycle → taps shift only on strobe edges. data_o = 10 exactly after the 4th strobe. State holds between strobes.
4. Flush priority: full line, then assert clr and en together with data_i = 99 → all taps = 0, fill_o = 0, full_o = 0, and 99 is not captured. The next en captures normally.
5. Async reset mid-stream: assert rst low between clock edges while en is streaming → outputs go to 0 before the next edge and stay 0 until release.
6. Sign and width: DEPTH = 1 with data_i = 25'h1000000 (most negative), then 25'h0FFFFFF → data_o reproduces each value exactly one enabled edge later. fill_o saturates at 1.
